// File: rtl/sdp_rdma_pkg.sv
// rtl/sdp_rdma_pkg.sv - shared types and defaults for the SDP RDMA read sequencer
package sdp_rdma_pkg;

  localparam int SDP_AW         = 64;
  localparam int SDP_W_W        = 13;
  localparam int SDP_MAX_REQ    = 8;
  localparam int SDP_ATOM_BYTES = 32;
  localparam int SDP_CRED_DEPTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DRAIN,
    ST_DONE
  } sdp_state_e;

  typedef struct packed {
    logic [SDP_AW-1:0] addr;
    logic [3:0]        size;
    logic              eol;
    logic              eos;
  } sdp_req_t;

endpackage

// File: rtl/sdp_rdma_cred_cnt.sv
// rtl/sdp_rdma_cred_cnt.sv - latency-buffer credit counter with saturation and sticky overflow flag
module sdp_rdma_cred_cnt
  import sdp_rdma_pkg::*;
#(
  parameter int CRED_DEPTH = SDP_CRED_DEPTH,
  parameter int CRED_W     = $clog2(CRED_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              dec_vld,
  input  logic [4:0]        dec_num,
  input  logic              inc_vld,
  input  logic [4:0]        inc_num,
  output logic [CRED_W-1:0] credits,
  output logic              full,
  output logic              err
);

  localparam int SW = ((CRED_W > 5) ? CRED_W : 5) + 2;

  logic [CRED_W-1:0] cnt;
  logic [SW-1:0]     sum;
  logic              over;

  // credits is the post-update count, so the issuer can decide next-cycle
  // validity from the same-cycle accept and return; dec never exceeds cnt.
  always_comb begin
    sum = SW'(cnt);
    if (dec_vld) sum = sum - SW'(dec_num);
    if (inc_vld) sum = sum + SW'(inc_num);
    over    = (sum > SW'(CRED_DEPTH));
    credits = over ? CRED_W'(CRED_DEPTH) : CRED_W'(sum);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= CRED_W'(CRED_DEPTH);
      err <= 1'b0;
    end else begin
      cnt <= credits;
      if (over) err <= 1'b1;
    end
  end

  assign full = (cnt == CRED_W'(CRED_DEPTH));

endmodule

// File: rtl/sdp_rdma_rd_seq.sv
// rtl/sdp_rdma_rd_seq.sv - surface walker issuing credit-gated DMA read requests for one SDP RDMA channel
module sdp_rdma_rd_seq
  import sdp_rdma_pkg::*;
#(
  parameter int AW         = SDP_AW,
  parameter int W_W        = SDP_W_W,
  parameter int MAX_REQ    = SDP_MAX_REQ,
  parameter int ATOM_BYTES = SDP_ATOM_BYTES,
  parameter int CRED_DEPTH = SDP_CRED_DEPTH
) (
  input  logic           nvdla_core_clk,
  input  logic           nvdla_core_rstn,
  input  logic           op_en,
  input  logic [AW-1:0]  cfg_base_addr,
  input  logic [W_W-1:0] cfg_width,
  input  logic [W_W-1:0] cfg_height,
  input  logic [AW-1:0]  cfg_line_stride,
  output logic           dma_rd_req_pvld,
  input  logic           dma_rd_req_prdy,
  output logic [AW-1:0]  dma_rd_req_addr,
  output logic [3:0]     dma_rd_req_size,
  output logic           dma_rd_req_eol,
  output logic           dma_rd_req_eos,
  input  logic           cred_ret_vld,
  input  logic [4:0]     cred_ret_num,
  output logic           busy,
  output logic           op_done,
  output logic           cred_err
);

  localparam int CRED_W = $clog2(CRED_DEPTH + 1);
  localparam int SH     = $clog2(ATOM_BYTES);
  localparam int XW     = W_W + 1;

  sdp_state_e        state;
  sdp_req_t          req_q;
  sdp_req_t          req_nxt;
  logic              pvld_q;
  logic [XW-1:0]     x, y;
  logic [AW-1:0]     line_base;
  logic [W_W-1:0]    width_q, height_q;
  logic [AW-1:0]     stride_q;

  logic              accept;
  logic [4:0]        n_acc;
  logic [XW-1:0]     x_adv, y_adv, rem;
  logic [AW-1:0]     lb_adv;
  logic [4:0]        n_nxt;
  logic [CRED_W-1:0] credits_nxt;
  logic              cred_full;

  assign accept = pvld_q & dma_rd_req_prdy;
  assign n_acc  = 5'(req_q.size) + 5'd1;

  // x/y/line_base always point at the request being presented (or about to
  // be); on accept they advance so the following request is ready next cycle.
  always_comb begin
    x_adv  = x;
    y_adv  = y;
    lb_adv = line_base;
    if (accept) begin
      if (!req_q.eol) begin
        x_adv = x + XW'(n_acc);
      end else begin
        x_adv  = '0;
        y_adv  = y + XW'(1);
        lb_adv = line_base + stride_q;
      end
    end
    rem          = XW'(width_q) + XW'(1) - x_adv;
    n_nxt        = (rem > XW'(MAX_REQ)) ? 5'(MAX_REQ) : 5'(rem);
    req_nxt.addr = lb_adv + (AW'(x_adv) << SH);
    req_nxt.size = 4'(n_nxt - 5'd1);
    req_nxt.eol  = (rem <= XW'(MAX_REQ));
    req_nxt.eos  = req_nxt.eol && (y_adv == XW'(height_q));
  end

  sdp_rdma_cred_cnt #(
    .CRED_DEPTH(CRED_DEPTH),
    .CRED_W    (CRED_W)
  ) u_cred (
    .clk    (nvdla_core_clk),
    .rstn   (nvdla_core_rstn),
    .dec_vld(accept),
    .dec_num(n_acc),
    .inc_vld(cred_ret_vld),
    .inc_num(cred_ret_num),
    .credits(credits_nxt),
    .full   (cred_full),
    .err    (cred_err)
  );

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      state     <= ST_IDLE;
      req_q     <= '0;
      pvld_q    <= 1'b0;
      x         <= '0;
      y         <= '0;
      line_base <= '0;
      width_q   <= '0;
      height_q  <= '0;
      stride_q  <= '0;
      busy      <= 1'b0;
      op_done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (op_en) begin
            width_q   <= cfg_width;
            height_q  <= cfg_height;
            stride_q  <= cfg_line_stride;
            line_base <= cfg_base_addr;
            x         <= '0;
            y         <= '0;
            busy      <= 1'b1;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          x         <= x_adv;
          y         <= y_adv;
          line_base <= lb_adv;
          if (accept && req_q.eos) begin
            pvld_q <= 1'b0;
            state  <= ST_DRAIN;
          end else if (!pvld_q || accept) begin
            // A held request keeps pvld: credits cannot drop without an accept.
            pvld_q <= (credits_nxt >= CRED_W'(n_nxt));
            req_q  <= req_nxt;
          end
        end
        ST_DRAIN: begin
          if (cred_full) begin
            busy    <= 1'b0;
            op_done <= 1'b1;
            state   <= ST_DONE;
          end
        end
        default: begin
          op_done <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign dma_rd_req_pvld = pvld_q;
  assign dma_rd_req_addr = req_q.addr;
  assign dma_rd_req_size = req_q.size;
  assign dma_rd_req_eol  = req_q.eol;
  assign dma_rd_req_eos  = req_q.eos;

endmodule

// File: tb/tb_sdp_rdma_rd_seq.sv
// tb/tb_sdp_rdma_rd_seq.sv - scoreboard bench for the SDP RDMA read-request sequencer
module tb_sdp_rdma_rd_seq;

  logic        clk;
  logic        rstn;
  logic        op_en;
  logic [63:0] cfg_base_addr;
  logic [12:0] cfg_width;
  logic [12:0] cfg_height;
  logic [63:0] cfg_line_stride;
  logic        pvld;
  logic        prdy;
  logic [63:0] addr;
  logic [3:0]  size;
  logic        eol;
  logic        eos;
  logic        cred_ret_vld;
  logic [4:0]  cred_ret_num;
  logic        busy;
  logic        op_done;
  logic        cred_err;

  sdp_rdma_rd_seq dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .op_en          (op_en),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_width      (cfg_width),
    .cfg_height     (cfg_height),
    .cfg_line_stride(cfg_line_stride),
    .dma_rd_req_pvld(pvld),
    .dma_rd_req_prdy(prdy),
    .dma_rd_req_addr(addr),
    .dma_rd_req_size(size),
    .dma_rd_req_eol (eol),
    .dma_rd_req_eos (eos),
    .cred_ret_vld   (cred_ret_vld),
    .cred_ret_num   (cred_ret_num),
    .busy           (busy),
    .op_done        (op_done),
    .cred_err       (cred_err)
  );

  typedef struct {
    logic [63:0] addr;
    int          size;
    bit          eol;
    bit          eos;
  } exp_t;

  typedef struct {
    int due;
    int num;
  } ret_t;

  exp_t exp_q[$];
  ret_t ret_q[$];
  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  int   cyc      = 0;
  int   acc_cnt  = 0;
  int   done_cnt = 0;
  bit   auto_ret = 0;
  bit   prev_done = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_req(input logic [63:0] a, input int sz, input bit l, input bit s);
    exp_t e;
    e.addr = a; e.size = sz; e.eol = l; e.eos = s;
    exp_q.push_back(e);
  endtask

  task automatic push_ret(input int due, input int num);
    ret_t r;
    r.due = due; r.num = num;
    ret_q.push_back(r);
  endtask

  // Monitor: pops the scoreboard on every accepted request and on op_done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && pvld && prdy) begin
        if (exp_q.size() == 0) begin
          tot_cnt++;
          $display("FAIL unexpected_req: got addr 0x%0h size %0d, expected no request", addr, size);
        end else begin
          e = exp_q.pop_front();
          chk("req_addr", addr, e.addr);
          chk("req_size", 64'(size), 64'(e.size));
          chk("req_eol_eos", {62'd0, eol, eos}, {62'd0, e.eol, e.eos});
        end
        acc_cnt++;
        if (auto_ret) push_ret(cyc + 5, int'(size) + 1);
      end
      if (op_done) begin
        done_cnt++;
        chk("done_busy_low", 64'(busy), 64'd0);
        chk("done_single_pulse", 64'(prev_done), 64'd0);
      end
      prev_done = op_done;
    end
  end

  // Sole driver of the credit-return port.
  initial begin
    ret_t r;
    cred_ret_vld = 0;
    cred_ret_num = 0;
    forever begin
      @(posedge clk);
      #1;
      if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
        r = ret_q.pop_front();
        cred_ret_vld = 1;
        cred_ret_num = 5'(r.num);
      end else begin
        cred_ret_vld = 0;
        cred_ret_num = 0;
      end
    end
  end

  task automatic start_op(input logic [63:0] base, input int w, input int h, input logic [63:0] stride);
    @(posedge clk);
    #1;
    cfg_base_addr   = base;
    cfg_width       = 13'(w);
    cfg_height      = 13'(h);
    cfg_line_stride = stride;
    op_en           = 1;
    @(posedge clk);
    #1;
    op_en = 0;
  endtask

  task automatic wait_done(input string name, input int d0, input int budget);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic wait_pvld(input string name, input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!pvld && k < budget);
    chk(name, 64'(pvld), 64'd1);
  endtask

  task automatic feed_returns(input int count, input int num);
    for (int i = 0; i < count; i++) push_ret(cyc + 1 + i, num);
  endtask

  initial begin
    int a0, d0;
    rstn = 0; op_en = 0; prdy = 0;
    cfg_base_addr = 0; cfg_width = 0; cfg_height = 0; cfg_line_stride = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pvld", 64'(pvld), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(op_done), 64'd0);
    chk("rst_cred_err", 64'(cred_err), 64'd0);
    @(posedge clk);
    #1 rstn = 1;

    // Basic two-line walk with a short tail per line.
    auto_ret = 1; prdy = 1; d0 = done_cnt;
    push_req(64'h1000, 7, 0, 0);
    push_req(64'h1100, 7, 0, 0);
    push_req(64'h1200, 3, 1, 0);
    push_req(64'h1400, 7, 0, 0);
    push_req(64'h1500, 7, 0, 0);
    push_req(64'h1600, 3, 1, 1);
    start_op(64'h1000, 19, 1, 64'h400);
    wait_done("walk_done", d0, 200);
    chk("walk_all_issued", 64'(exp_q.size()), 64'd0);

    // Credit stall: 128 atoms on one line, no returns.
    auto_ret = 0; prdy = 1; d0 = done_cnt; a0 = acc_cnt;
    for (int i = 0; i < 16; i++) push_req(64'h8000 + 64'(i) * 256, 7, i == 15, i == 15);
    start_op(64'h8000, 127, 0, 64'h0);
    repeat (20) @(negedge clk);
    chk("stall_accepts", 64'(acc_cnt - a0), 64'd8);
    chk("stall_pvld_low", 64'(pvld), 64'd0);
    push_ret(cyc + 1, 8);
    repeat (8) @(negedge clk);
    chk("stall_one_more", 64'(acc_cnt - a0), 64'd9);
    chk("stall_pvld_low2", 64'(pvld), 64'd0);
    feed_returns(15, 8);
    wait_done("stall_done", d0, 200);
    chk("stall_all_issued", 64'(exp_q.size()), 64'd0);

    // Backpressure mid-line, plus op_en and cfg churn that must be ignored.
    auto_ret = 1; prdy = 1; d0 = done_cnt;
    push_req(64'h2000, 7, 0, 0);
    push_req(64'h2100, 7, 0, 0);
    push_req(64'h2200, 7, 0, 0);
    push_req(64'h2300, 7, 1, 1);
    start_op(64'h2000, 31, 0, 64'h0);
    wait_pvld("bp_first_pvld", 10);
    @(posedge clk);
    #1 prdy = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_pvld_held", 64'(pvld), 64'd1);
      chk("bp_addr_held", addr, 64'h2100);
      chk("bp_size_held", 64'(size), 64'd7);
      chk("bp_eol_held", 64'(eol), 64'd0);
      if (i == 1) begin
        op_en = 1; cfg_base_addr = 64'hDEAD000; cfg_width = 13'd3;
      end else begin
        op_en = 0;
      end
    end
    op_en = 0;
    @(posedge clk);
    #1 prdy = 1;
    wait_done("bp_done", d0, 200);
    chk("bp_all_issued", 64'(exp_q.size()), 64'd0);

    // Accept of 8 coincident with a return of 8 leaves credits at 64.
    auto_ret = 0; prdy = 0; d0 = done_cnt; a0 = acc_cnt;
    for (int i = 0; i < 16; i++) push_req(64'h4000 + 64'(i) * 256, 7, i == 15, i == 15);
    start_op(64'h4000, 127, 0, 64'h0);
    wait_pvld("sim_pvld", 10);
    push_ret(cyc + 1, 8);
    @(posedge clk);
    #1 prdy = 1;
    repeat (25) @(negedge clk);
    chk("sim_accepts", 64'(acc_cnt - a0), 64'd9);
    chk("sim_no_err", 64'(cred_err), 64'd0);
    feed_returns(15, 8);
    wait_done("sim_done", d0, 200);

    // Excess return at full credits, then a single-atom surface.
    push_ret(cyc + 1, 1);
    repeat (3) @(negedge clk);
    chk("excess_cred_err", 64'(cred_err), 64'd1);
    prdy = 1; d0 = done_cnt;
    push_req(64'h9000, 0, 1, 1);
    start_op(64'h9000, 0, 0, 64'h0);
    @(negedge clk);
    chk("lat_busy_t1", 64'(busy), 64'd1);
    chk("lat_pvld_t1", 64'(pvld), 64'd0);
    @(negedge clk);
    chk("lat_pvld_t2", 64'(pvld), 64'd1);
    repeat (6) @(negedge clk);
    chk("drain_no_done", 64'(done_cnt - d0), 64'd0);
    chk("drain_busy", 64'(busy), 64'd1);
    push_ret(cyc + 1, 1);
    begin
      int k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!op_done && k < 10);
      chk("single_op_done", 64'(op_done), 64'd1);
    end
    op_en = 1;
    @(posedge clk);
    #1 op_en = 0;
    repeat (3) begin
      @(negedge clk);
      chk("done_op_en_ignored", 64'(busy), 64'd0);
    end
    chk("single_issued", 64'(exp_q.size()), 64'd0);

    // Reset while a request is presented.
    auto_ret = 1; prdy = 0;
    start_op(64'hA000, 63, 0, 64'h0);
    wait_pvld("rst_mid_pvld", 10);
    @(posedge clk);
    #1 rstn = 0;
    @(posedge clk);
    #1 rstn = 1;
    @(negedge clk);
    chk("rst_mid_pvld_low", 64'(pvld), 64'd0);
    chk("rst_mid_busy_low", 64'(busy), 64'd0);
    chk("rst_mid_err_clr", 64'(cred_err), 64'd0);
    prdy = 1; d0 = done_cnt;
    push_req(64'hA000, 7, 0, 0);
    push_req(64'hA100, 7, 1, 1);
    start_op(64'hA000, 15, 0, 64'h0);
    wait_done("restart_done", d0, 200);
    chk("final_all_issued", 64'(exp_q.size()), 64'd0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
